adder_bist: RTL and testbench
=============================

# adder_bist

Built-in self-test stage wrapped around the `adder_top` ripple adder. It drives operand vectors into the adder's `a`/`b`/`cin` inputs and consumes its `s`/`cout` result. Each result is compared against an internally computed golden sum. Mismatches are counted, the first failing vector is captured, and a single pass/fail verdict is reported. This is the hardware replacement for bench-only operand sweeps, so the adder can be checked on the fabric.

## Interface
- `WIDTH`, 8: operand width; must match `adder_top`.
- `SETTLE`, 1: idle cycles (≥1) between driving a vector and sampling the result.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level sampled in IDLE; launches a run.
- `mode` in 2: sampled at start. Encodings:
  - 00: sweep `a`, `b`=0.
  - 01: sweep `b`, `a`=0.
  - 10: exhaustive, `b` outer and `a` inner.
  - 11: treated as 00.
- `cin_cfg` in 1: carry-in for the whole run; sampled at start.
- `a`, `b` out WIDTH: operands to adder; registered.
- `cin` out 1: carry-in to adder; registered.
- `s` in WIDTH: adder sum.
- `cout` in 1: adder carry-out.
- `busy` out 1: high from the first WAIT cycle through the DONE cycle.
- `done` out 1: one-cycle pulse at end of run.
- `pass` out 1: 1 iff zero mismatches; updated at DONE and held until the next start.
- `err_count` out 16: mismatch count; saturates at 16'hFFFF.
- `fail_valid` out 1: a mismatch has been captured this run.
- `fail_a`, `fail_b` out WIDTH: operands of the first mismatch.

## Operation
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE, `start`=1:
  - Latch `mode` and `cin_cfg`.
  - Clear `err_count`, `fail_valid`, `fail_a`, `fail_b`, `pass`.
  - Load vector 0 (`a`=0, `b`=0), drive `cin`=`cin_cfg`, go to WAIT.
- WAIT: hold the operands for SETTLE cycles, then go to CHECK.
- CHECK (exactly 1 cycle):
  - Compare {`cout`,`s`} against the (WIDTH+1)-bit sum `a`+`b`+`cin`.
  - On mismatch: increment `err_count` (saturating).
  - On mismatch with `fail_valid`=0: capture `a`/`b` and set `fail_valid`.
  - If this was the last vector, go to DONE. Otherwise load the next vector and go to WAIT.
- Vector order:
  - Modes 00/11: `a` = 0..2^WIDTH−1, 2^WIDTH vectors.
  - Mode 01: the same sequence applied to `b`.
  - Mode 10: `a` increments each vector. On `a` wrap from all-ones to 0, `b` increments. The run ends after `a`=`b`=all-ones; 2^(2·WIDTH) vectors.
  - The sweeping operand never wraps into a second pass.
- DONE (1 cycle): pulse `done`, set `pass` = (`err_count`==0), go to IDLE. Operands keep their last values.
- `start` is ignored in WAIT, CHECK and DONE. A `start` coincident with DONE is dropped.
- Reset asserted mid-run aborts immediately:
  - FSM returns to IDLE.
  - All outputs take their reset values.
  - No `done` pulse is generated.

## Timing
- Reset values: all outputs 0, FSM in IDLE.
- With `start` seen in cycle 0:
  - Vector 0 is on `a`/`b`/`cin` in cycle 1.
  - Vector k is checked in cycle (SETTLE+1)·k + SETTLE + 1.
- `done` pulses in cycle (SETTLE+1)·N + 1, where N is the vector count.
  - Example: WIDTH=8, SETTLE=1, mode 00 gives `done` in cycle 513.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- The adder path is combinational. `s`/`cout` must be stable within SETTLE cycles of an operand change; no handshake with the adder.
- `err_count`/`fail_*` update on the clock edge ending the CHECK cycle.

## Test plan
- Good adder, WIDTH=8, SETTLE=1, mode 00, `cin_cfg`=1:
  - `done` at cycle 513, `pass`=1, `err_count`=0, `fail_valid`=0.
  - `a` ends at 8'hFF.
- Mode 10 on a good adder, `cin_cfg`=0:
  - `done` at cycle 131073, `pass`=1.
  - Spot-check: `b` increments exactly when `a` wraps 8'hFF→8'h00.
- Faulty adder model, `cout` stuck at 0, mode 00, `cin_cfg`=1:
  - Failing vectors `a`=8'hFF only → `err_count`=1, `pass`=0.
  - `fail_a`=8'hFF, `fail_b`=8'h00.
- Faulty model, `s[0]` inverted, mode 01:
  - `err_count`=256, `fail_a`=0, `fail_b`=0, `pass`=0.
- Assert `start` again while `busy`=1, and in the DONE cycle:
  - Ignored; no restart, timing unchanged.
  - A `start` in the following IDLE cycle launches a new run and clears the counters.
- Drop `rst_n` at cycle 200 of a mode 00 run:
  - All outputs 0 asynchronously, no `done`.
  - After release, a new `start` gives a full pass run.

Source files
------------

// File: rtl/adder_bist_if.sv
// rtl/adder_bist_if.sv - operand/result bundle between the BIST stage and the adder under test
//
// Signals:
//   a, b  : operands driven towards the adder
//   cin   : carry-in driven towards the adder
//   s     : adder sum returned to the checker
//   cout  : adder carry-out returned to the checker
// Modports:
//   master : BIST side (drives a/b/cin, observes s/cout)
//   slave  : adder side (observes a/b/cin, drives s/cout)
interface adder_bist_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (output a, output b, output cin, input s, input cout);
  modport slave  (input a, input b, input cin, output s, output cout);
endinterface

// File: rtl/adder_bist.sv
// rtl/adder_bist.sv - built-in self-test sweeping operand vectors through a combinational adder
//
// Parameters:
//   WIDTH  : operand width, must match the adder under test
//   SETTLE : idle cycles (>=1) between driving a vector and sampling the result
// Ports:
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   start            : launches a run when seen in IDLE
//   mode             : 00 sweep a, 01 sweep b, 10 exhaustive (b outer, a inner), 11 as 00
//   cin_cfg          : carry-in used for the whole run
//   add (master)     : registered a/b/cin towards the adder, s/cout back from it
//   busy             : high from the first WAIT cycle through the DONE cycle
//   done             : one-cycle end-of-run pulse
//   pass             : zero mismatches in the last run, held until the next start
//   err_count        : saturating mismatch count
//   fail_valid       : a failing vector has been captured this run
//   fail_a, fail_b   : operands of the first failing vector
module adder_bist #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             cin_cfg,
  adder_bist_if.master     add,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  state_t           state_q;
  logic [1:0]       mode_q;
  logic             cin_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [15:0]      err_q;
  logic             fv_q;
  logic [WIDTH-1:0] fa_q;
  logic [WIDTH-1:0] fb_q;

  logic [WIDTH:0]   golden_d;
  logic             mismatch_d;
  logic [15:0]      err_d;
  logic             last_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  always_comb begin
    golden_d   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    mismatch_d = ({add.cout, add.s} != golden_d);
    err_d      = (mismatch_d && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;

    // Only the sweeping operand(s) decide the end of the run; the other
    // operand stays at zero so it never wraps into a second pass.
    last_d = 1'b0;
    a_d    = a_q;
    b_d    = b_q;
    case (mode_q)
      2'b01: begin
        last_d = (b_q == ONES);
        b_d    = b_q + 1'b1;
      end
      2'b10: begin
        last_d = (a_q == ONES) && (b_q == ONES);
        a_d    = a_q + 1'b1;
        b_d    = (a_q == ONES) ? b_q + 1'b1 : b_q;
      end
      default: begin
        last_d = (a_q == ONES);
        a_d    = a_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 16'd0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= (mode == 2'b11) ? 2'b00 : mode;
            cin_q   <= cin_cfg;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 16'd0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mismatch_d && !fv_q) begin
            fv_q <= 1'b1;
            fa_q <= a_q;
            fb_q <= b_q;
          end
          if (last_d) begin
            // Verdict is registered alongside done so both appear in the DONE cycle.
            done_q  <= 1'b1;
            pass_q  <= (err_d == 16'd0);
            state_q <= S_DONE;
          end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign add.a      = a_q;
  assign add.b      = b_q;
  assign add.cin    = cin_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;

endmodule

// File: tb/tb_adder_bist.sv
// tb/tb_adder_bist.sv - self-checking bench for adder_bist with behavioural adder and run model
module tb_adder_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  // 8-bit instance, SETTLE=1
  logic       start8, cin8;
  logic [1:0] mode8;
  logic       busy8, done8, pass8, fv8;
  logic [15:0] err8;
  logic [7:0] fa8, fb8;
  int         kind8 = 0, flt_a8 = 0, flt_b8 = 0;
  logic [8:0] res8;
  adder_bist_if #(.WIDTH(8)) if8 ();

  // 4-bit instance, SETTLE=2, used for the exhaustive mode
  logic       start4, cin4;
  logic [1:0] mode4;
  logic       busy4, done4, pass4, fv4;
  logic [15:0] err4;
  logic [3:0] fa4, fb4;
  int         kind4 = 0, flt_a4 = 0, flt_b4 = 0;
  logic [4:0] res4;
  adder_bist_if #(.WIDTH(4)) if4 ();

  // Adder under test: 0 good, 1 cout stuck at 0, 2 s[0] inverted, 3 s[0] flipped on one vector
  function automatic int adder_fn(int a, int b, int ci, int kind, int fa, int fb, int w);
    int r;
    r = a + b + ci;
    if (kind == 1)                          r = r & ((1 << w) - 1);
    else if (kind == 2)                     r = r ^ 1;
    else if (kind == 3 && a == fa && b == fb) r = r ^ 1;
    return r;
  endfunction

  assign res8    = 9'(adder_fn(int'(if8.a), int'(if8.b), int'(if8.cin), kind8, flt_a8, flt_b8, 8));
  assign if8.s    = res8[7:0];
  assign if8.cout = res8[8];
  assign res4    = 5'(adder_fn(int'(if4.a), int'(if4.b), int'(if4.cin), kind4, flt_a4, flt_b4, 4));
  assign if4.s    = res4[3:0];
  assign if4.cout = res4[4];

  adder_bist #(.WIDTH(8), .SETTLE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .cin_cfg(cin8), .add(if8),
    .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
    .fail_valid(fv8), .fail_a(fa8), .fail_b(fb8)
  );

  adder_bist #(.WIDTH(4), .SETTLE(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .cin_cfg(cin4), .add(if4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .fail_valid(fv4), .fail_a(fa4), .fail_b(fb4)
  );

  // Reference: enumerate the run's vectors and score the adder against true addition
  task automatic model(input int md, input int ci, input int kind, input int fa, input int fb,
                       input int w, output int n, output int errs, output int fv,
                       output int fa_o, output int fb_o);
    int m, lim, outer_lim, va, vb;
    m = (md == 3) ? 0 : md;
    lim = 1 << w;
    outer_lim = (m == 2) ? lim : 1;
    n = 0; errs = 0; fv = 0; fa_o = 0; fb_o = 0;
    for (int o = 0; o < outer_lim; o++) begin
      for (int i = 0; i < lim; i++) begin
        if (m == 2)      begin va = i; vb = o; end
        else if (m == 1) begin va = 0; vb = i; end
        else             begin va = i; vb = 0; end
        n++;
        if (adder_fn(va, vb, ci, kind, fa, fb, w) != va + vb + ci) begin
          errs++;
          if (fv == 0) begin fv = 1; fa_o = va; fb_o = vb; end
        end
      end
    end
  endtask

  task automatic run8(input int md, input int ci, input int hold, output int dcyc,
                      output int busy_bad, output logic [16:0] v0);
    @(negedge clk);
    start8 = 1'b1; mode8 = 2'(md); cin8 = 1'(ci);
    @(posedge clk);
    #1;
    if (hold == 0) start8 = 1'b0;
    dcyc = -1; busy_bad = 0; v0 = '1;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      if (c == 1) v0 = {if8.a, if8.b, if8.cin};
      if (busy8 !== 1'b1) busy_bad++;
      if (done8 === 1'b1) begin dcyc = c; break; end
    end
  endtask

  task automatic run4(input int ci, output int dcyc, output int wrap_bad, output int wraps);
    int pa, pb, a, b;
    @(negedge clk);
    start4 = 1'b1; mode4 = 2'b10; cin4 = 1'(ci);
    @(posedge clk);
    #1 start4 = 1'b0;
    dcyc = -1; wrap_bad = 0; wraps = 0; pa = 0; pb = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      a = int'(if4.a); b = int'(if4.b);
      if (a != pa) begin
        if (pa == 15) begin
          wraps++;
          if (!(a == 0 && b == pb + 1)) wrap_bad++;
        end else if (!(a == pa + 1 && b == pb)) wrap_bad++;
      end else if (b != pb) wrap_bad++;
      pa = a; pb = b;
      if (done4 === 1'b1) begin dcyc = c; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 0; mode8 = 0; cin8 = 0; start4 = 0; mode4 = 0; cin4 = 0;
    #12;
    n_cmp++;
    if ({if8.a, if8.b, if8.cin} !== 17'd0) begin
      n_bad++; $display("FAIL reset_operands: got %h want 0", {if8.a, if8.b, if8.cin});
    end
    n_cmp++;
    if ({busy8, done8, pass8, fv8, err8} !== 20'd0) begin
      n_bad++; $display("FAIL reset_status: got %h want 0", {busy8, done8, pass8, fv8, err8});
    end
    n_cmp++;
    if ({fa8, fb8, busy4, done4, err4} !== 34'd0) begin
      n_bad++; $display("FAIL reset_capture: got %h want 0", {fa8, fb8, busy4, done4, err4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode00_good();
    int d, bb;
    logic [16:0] v0;
    kind8 = 0;
    run8(0, 1, 0, d, bb, v0);
    n_cmp++; if (d !== 513) begin n_bad++; $display("FAIL m00_done_cycle: got %0d want 513", d); end
    n_cmp++; if (bb !== 0) begin n_bad++; $display("FAIL m00_busy: got %0d low cycles want 0", bb); end
    n_cmp++; if (v0 !== 17'h00001) begin n_bad++; $display("FAIL m00_vec0: got %h want 00001", v0); end
    n_cmp++;
    if ({pass8, fv8, err8} !== {1'b1, 1'b0, 16'd0}) begin
      n_bad++; $display("FAIL m00_verdict: got pass=%b fv=%b err=%0d want 1 0 0", pass8, fv8, err8);
    end
    n_cmp++;
    if ({if8.a, if8.b} !== 16'hFF00) begin
      n_bad++; $display("FAIL m00_last_vec: got %h want ff00", {if8.a, if8.b});
    end
    @(negedge clk);
    n_cmp++;
    if ({done8, busy8, pass8} !== 3'b001) begin
      n_bad++; $display("FAIL m00_after_done: got done/busy/pass=%b want 001", {done8, busy8, pass8});
    end
  endtask

  task automatic test_cout_stuck();
    int d, bb;
    logic [16:0] v0;
    kind8 = 1;
    run8(0, 1, 0, d, bb, v0);
    n_cmp++; if (d !== 513) begin n_bad++; $display("FAIL cout_done_cycle: got %0d want 513", d); end
    n_cmp++;
    if ({err8, pass8, fv8, fa8, fb8} !== {16'd1, 1'b0, 1'b1, 8'hFF, 8'h00}) begin
      n_bad++; $display("FAIL cout_result: got err=%0d pass=%b fv=%b fa=%h fb=%h want 1 0 1 ff 00",
                        err8, pass8, fv8, fa8, fb8);
    end
  endtask

  task automatic test_s0_inv();
    int d, bb;
    logic [16:0] v0;
    kind8 = 2;
    run8(1, 0, 0, d, bb, v0);
    n_cmp++; if (d !== 513) begin n_bad++; $display("FAIL s0_done_cycle: got %0d want 513", d); end
    n_cmp++;
    if ({err8, pass8, fv8, fa8, fb8} !== {16'd256, 1'b0, 1'b1, 8'h00, 8'h00}) begin
      n_bad++; $display("FAIL s0_result: got err=%0d pass=%b fv=%b fa=%h fb=%h want 256 0 1 00 00",
                        err8, pass8, fv8, fa8, fb8);
    end
    n_cmp++;
    if ({if8.a, if8.b} !== 16'h00FF) begin
      n_bad++; $display("FAIL s0_last_vec: got %h want 00ff", {if8.a, if8.b});
    end
  endtask

  task automatic test_random();
    int md, ci, n, errs, fv, efa, efb, d, bb;
    logic [16:0] v0;
    for (int it = 0; it < 6; it++) begin
      md = $urandom_range(0, 2);
      if (md == 2) md = 3;
      ci = $urandom_range(0, 1);
      kind8 = $urandom_range(0, 3);
      flt_a8 = $urandom_range(0, 255);
      flt_b8 = $urandom_range(0, 255);
      if (kind8 == 3 && $urandom_range(0, 3) != 0) begin
        if (md == 1) flt_a8 = 0; else flt_b8 = 0;
      end
      model(md, ci, kind8, flt_a8, flt_b8, 8, n, errs, fv, efa, efb);
      run8(md, ci, 0, d, bb, v0);
      n_cmp++;
      if (d !== 2 * n + 1) begin n_bad++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", it, d, 2 * n + 1); end
      n_cmp++;
      if ({err8, fv8, pass8} !== {16'(errs), 1'(fv), 1'(errs == 0)}) begin
        n_bad++; $display("FAIL rnd%0d_counts: got err=%0d fv=%b pass=%b want %0d %0d %0d",
                          it, err8, fv8, pass8, errs, fv, errs == 0);
      end
      n_cmp++;
      if ({fa8, fb8} !== {8'(efa), 8'(efb)}) begin
        n_bad++; $display("FAIL rnd%0d_capture: got %h/%h want %h/%h", it, fa8, fb8, 8'(efa), 8'(efb));
      end
    end
  endtask

  task automatic test_exhaustive();
    int d, wb, wr, ci, n, errs, fv, efa, efb;
    kind4 = 0;
    run4(0, d, wb, wr);
    n_cmp++; if (d !== 769) begin n_bad++; $display("FAIL exh_done_cycle: got %0d want 769", d); end
    n_cmp++;
    if (wb !== 0 || wr !== 15) begin
      n_bad++; $display("FAIL exh_b_step: got %0d bad steps %0d wraps want 0 15", wb, wr);
    end
    n_cmp++;
    if ({pass4, err4, if4.a, if4.b} !== {1'b1, 16'd0, 4'hF, 4'hF}) begin
      n_bad++; $display("FAIL exh_verdict: got pass=%b err=%0d a=%h b=%h want 1 0 f f", pass4, err4, if4.a, if4.b);
    end
    kind4 = 3; flt_a4 = $urandom_range(0, 15); flt_b4 = $urandom_range(0, 15);
    ci = $urandom_range(0, 1);
    model(2, ci, 3, flt_a4, flt_b4, 4, n, errs, fv, efa, efb);
    run4(ci, d, wb, wr);
    n_cmp++;
    if ({err4, pass4, fv4, fa4, fb4} !== {16'(errs), 1'(errs == 0), 1'(fv), 4'(efa), 4'(efb)}) begin
      n_bad++; $display("FAIL exh_fault: got err=%0d pass=%b fa=%h fb=%h want %0d %0d %h %h",
                        err4, pass4, fa4, fb4, errs, errs == 0, 4'(efa), 4'(efb));
    end
  endtask

  task automatic test_start_ignored();
    int d, bb, d2;
    logic [16:0] v0;
    kind8 = 1;
    run8(0, 1, 1, d, bb, v0);
    n_cmp++; if (d !== 513) begin n_bad++; $display("FAIL hold_done_cycle: got %0d want 513", d); end
    n_cmp++; if (err8 !== 16'd1) begin n_bad++; $display("FAIL hold_err: got %0d want 1", err8); end
    kind8 = 0;
    @(negedge clk);
    n_cmp++;
    if ({busy8, done8, err8} !== {1'b0, 1'b0, 16'd1}) begin
      n_bad++; $display("FAIL hold_done_start_dropped: got busy=%b done=%b err=%0d want 0 0 1", busy8, done8, err8);
    end
    @(posedge clk);
    #1 start8 = 1'b0;
    d2 = -1;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({busy8, err8, fv8, pass8} !== {1'b1, 16'd0, 1'b0, 1'b0}) begin
          n_bad++; $display("FAIL restart_clear: got busy=%b err=%0d fv=%b pass=%b want 1 0 0 0", busy8, err8, fv8, pass8);
        end
      end
      if (done8 === 1'b1) begin d2 = c; break; end
    end
    n_cmp++;
    if (d2 !== 513 || pass8 !== 1'b1) begin
      n_bad++; $display("FAIL restart_run: got done cycle %0d pass=%b want 513 1", d2, pass8);
    end
  endtask

  task automatic test_reset_midrun();
    int dones, busys, d, bb;
    logic [16:0] v0;
    kind8 = 0; dones = 0; busys = 0;
    @(negedge clk);
    start8 = 1'b1; mode8 = 2'b00; cin8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if8.a, if8.b, if8.cin, busy8, done8, pass8, err8, fv8, fa8, fb8} !== 53'd0) begin
      n_bad++; $display("FAIL midrst_async: got a=%h b=%h busy=%b err=%0d want all 0", if8.a, if8.b, busy8, err8);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
      if (busy8 === 1'b1) busys++;
    end
    n_cmp++;
    if (dones !== 0 || busys !== 0) begin
      n_bad++; $display("FAIL midrst_no_done: got %0d done %0d busy cycles want 0 0", dones, busys);
    end
    run8(0, 1, 0, d, bb, v0);
    n_cmp++;
    if (d !== 513 || pass8 !== 1'b1 || err8 !== 16'd0) begin
      n_bad++; $display("FAIL midrst_rerun: got done cycle %0d pass=%b err=%0d want 513 1 0", d, pass8, err8);
    end
  endtask

  initial begin
    test_reset();
    test_mode00_good();
    test_cout_stuck();
    test_s0_inv();
    test_random();
    test_exhaustive();
    test_start_ignored();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
